hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and flush sequencer for the 5-stage RV32 core. It watches the ID, EX and MEM stages and drives write-enables and flushes into PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It handles three cases: load-use stalls, multi-cycle redirect bubbles after taken branches and jumps, and data-memory wait freezes. It is the single owner of every pipeline-register `flush` and hold signal.

## Interface
- `FLUSH_CYCLES`, default 2: IF-side bubbles after a redirect; legal range 1..7.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: reset; asynchronous, active-low.
- `id_rs1, id_rs2  in  5`: source registers of the instruction in ID.
- `id_use_rs1, id_use_rs2  in  1`: ID instruction actually reads rs1 / rs2.
- `ex_rd  in  5`: destination register in EX.
- `ex_MR  in  1`: EX instruction is a load.
- `ex_redirect  in  1`: branch taken or `jmp` resolved in EX.
- `mem_req  in  1`: MEM stage is accessing data memory.
- `mem_ack  in  1`: data memory completes the access this cycle.
- `pc_we, ifid_we, idex_we, exmem_we  out  1`: stage register write enables.
- `ifid_flush, idex_flush, memwb_flush  out  1`: synchronous bubble inserts.
- `pc_redirect  out  1`: select the EX target for the PC.
- `busy  out  1`: FSM is not in RUN.
- `stall_cnt, flush_cnt  out  32`: exist only when `HAZARD_PERF_CNT_EN` is defined.

## Operation
- FSM states: RUN, REDIR, MWAIT. Outputs are Mealy: they depend on the current state and the current inputs.
- Default outputs (no event): all `*_we`=1, all flushes=0, `pc_redirect`=0.
- Event priority, highest first: memory wait, then redirect, then load-use.
- **Memory wait**: `mem_req && !mem_ack`.
  - All four `*_we`=0, `memwb_flush`=1, every other flush=0.
  - RUN or REDIR→MWAIT. In REDIR the FSM records the return state and the counter holds.
- **MWAIT**:
  - While `!mem_ack`: same frozen outputs.
  - On `mem_ack`: default outputs this cycle, then return to the recorded state (RUN or REDIR).
  - `ex_redirect` and load-use are ignored while frozen; they are re-evaluated after release because EX is held.
- **Redirect** (in RUN): `pc_redirect`=1, `ifid_flush`=1, `idex_flush`=1.
  - If `FLUSH_CYCLES`>1: load counter = `FLUSH_CYCLES`-1 and go to REDIR. Otherwise stay in RUN.
- **REDIR**: each cycle `ifid_flush`=1, `pc_we`=1, counter decrements. Go to RUN when the counter reaches 0 (same edge).
  - `ex_redirect` in REDIR is ignored; EX holds a bubble.
- **Load-use** (RUN only): `ex_MR && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))`.
  - `pc_we`=0, `ifid_we`=0, `idex_flush`=1 for exactly one cycle; stay in RUN.
  - rd=x0 never stalls.
- `busy` = (state != RUN).

## Timing
- Reset asserted (`rst`=0):
  - State RUN, counter 0, return state RUN, perf counters 0.
  - Outputs forced regardless of inputs: all `*_we`=0, all flushes=1, `pc_redirect`=0, `busy`=0.
- First edge after deassertion behaves as RUN with normal evaluation.
- Reset mid-REDIR or mid-MWAIT: immediate return to the reset values above; no pending bubbles survive.
- Load-use penalty: 1 cycle. Redirect penalty: `FLUSH_CYCLES` cycles. Memory wait: cycles until `mem_ack`.
- A zero-wait access (`mem_req && mem_ack` in the same cycle) causes no stall.
- Simultaneous redirect and load-use: redirect wins and the load-use stall is dropped, since the ID instruction is flushed.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments every cycle with `pc_we`=0.
  - `flush_cnt` increments every cycle with `ifid_flush`=1.
  - Both saturate at 0xFFFFFFFF, with asynchronous reset to 0.
- Undefined: both ports and their registers are absent; control behaviour is identical.

## Test plan
- Load `x5` in EX, ID `add x6,x5,x1` with `id_use_rs1`=1 → one cycle `pc_we`=0, `ifid_we`=0, `idex_flush`=1, then defaults. Same case with `ex_rd`=0 → no stall.
- `ex_redirect`=1 in RUN, `FLUSH_CYCLES`=3 → cycle 0: `pc_redirect`, `ifid_flush`, `idex_flush`=1; cycles 1–2: `ifid_flush`=1, `busy`=1; cycle 3: RUN.
- `mem_req`=1 with `mem_ack` low for 4 cycles → 4 cycles of all `*_we`=0 and `memwb_flush`=1; the ack cycle shows defaults.
- Memory wait arriving in REDIR cycle 1 for 2 cycles → counter holds, and REDIR resumes with its remaining bubble.
- Drive `rst`=0 in MWAIT → outputs take reset values within the same cycle; after release, `busy`=0.
- With `HAZARD_PERF_CNT_EN`: one load-use, one redirect (`FLUSH_CYCLES`=2) and a 3-cycle wait → `stall_cnt`=4, `flush_cnt`=2.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline hazard and flush sequencer for the 5-stage RV32 core.
//
// Watches ID, EX and MEM and is the single owner of every pipeline-register
// write enable and flush. Three hazards are handled, highest priority first:
//   1. data-memory wait   : whole pipe frozen, bubble pushed into MEM/WB
//   2. EX redirect        : PC takes the EX target, IF/ID and ID/EX flushed,
//                           then FLUSH_CYCLES-1 extra IF-side bubbles (REDIR)
//   3. load-use           : one-cycle stall of PC and IF/ID, bubble into ID/EX
//
// Parameters:
//   FLUSH_CYCLES  IF-side bubbles after a redirect, legal range 1..7
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters (stall_cnt, flush_cnt). Without it the ports are absent.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/2  ID source registers and their use flags
//   ex_rd, ex_MR, ex_redirect    EX destination, load flag, taken branch/jump
//   mem_req, mem_ack             MEM data-memory access and its completion
//   pc_we..exmem_we              stage register write enables
//   ifid/idex/memwb_flush        synchronous bubble inserts
//   pc_redirect                  select the EX target for the PC
//   busy                         FSM is outside RUN
//   stall_cnt, flush_cnt         perf counters (HAZARD_PERF_CNT_EN only)
//
// All control outputs are Mealy: a function of the current state and the
// current inputs. While rst is low they are forced to a safe "everything
// held, everything flushed" pattern independent of the inputs.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_MR,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        pc_redirect,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REDIR = 2'd1,
    S_MWAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;    // state to resume after a memory wait
  logic [2:0] cnt_q, cnt_d;    // remaining REDIR bubbles

  logic mem_wait;
  logic load_use;

  assign mem_wait = mem_req && !mem_ack;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_MR && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    pc_redirect = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          memwb_flush = 1'b1;
          ret_d       = S_RUN;
          state_d     = S_MWAIT;
        end else if (ex_redirect) begin
          // A simultaneous load-use is dropped: its ID instruction is flushed.
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            cnt_d   = 3'(FLUSH_CYCLES - 1);
            state_d = S_REDIR;
          end
        end else if (load_use) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end
      end

      S_REDIR: begin
        // ex_redirect is ignored here: EX only holds a bubble.
        if (mem_wait) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          memwb_flush = 1'b1;
          ret_d       = S_REDIR;
          state_d     = S_MWAIT;
        end else begin
          ifid_flush = 1'b1;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = S_RUN;
          end
        end
      end

      S_MWAIT: begin
        // Redirect and load-use are not looked at while frozen; EX is held,
        // so they are seen again once the pipe is released.
        if (!mem_ack) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_we    = 1'b0;
          memwb_flush = 1'b1;
        end else begin
          state_d = ret_q;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    // Reset overrides everything: hold every stage and flush every bubble.
    if (!rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      pc_redirect = 1'b0;
    end
  end

  assign busy = rst && (state_q != S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      ret_q   <= S_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pc_we && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
